// File: rtl/video_testcard_pkg.sv
// ============================================================================
// Module : video_testcard_pkg
// Brief  : Test-mode codes and sequencer state encodings for the testcard.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package video_testcard_pkg;

  localparam logic [2:0] MODE_GRID        = 3'd0;
  localparam logic [2:0] MODE_MOVING_GRID = 3'd1;
  localparam logic [2:0] MODE_FONT        = 3'd2;
  localparam logic [2:0] MODE_WHITE       = 3'd3;
  localparam logic [2:0] MODE_HLINES      = 3'd4;
  localparam logic [2:0] MODE_VLINES      = 3'd5;

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_PEND = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

endpackage

`default_nettype wire

// File: rtl/button_debounce.sv
// ============================================================================
// Module : button_debounce
// Brief  : Synchroniser, stable-count debouncer and rising-edge pulse.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int DEBOUNCE_WIDTH  = 18
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic pulse_o
);

  localparam logic [DEBOUNCE_WIDTH-1:0] CNT_LAST = DEBOUNCE_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [1:0]                sync_q;
  logic                      stable_q, stable_d;
  logic [DEBOUNCE_WIDTH-1:0] cnt_q, cnt_d;
  logic                      pulse_q;

  // The counter only runs while the synchronised input disagrees with the
  // accepted level; any bounce back restarts it from zero.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == CNT_LAST) stable_d = sync_q[1];
      else                   cnt_d    = cnt_q + DEBOUNCE_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], btn_i};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      pulse_q  <= stable_d & ~stable_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

`default_nettype wire

// File: rtl/video_mode_sequencer.sv
// ============================================================================
// Module : video_mode_sequencer
// Brief  : Frame-synchronous test-mode / scroll-offset controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module video_mode_sequencer
  import video_testcard_pkg::*;
#(
  parameter int NUM_MODES       = 6,
  parameter int MODE_WIDTH      = 3,
  parameter int DWELL_FRAMES    = 50,
  parameter int DWELL_WIDTH     = 8,
  parameter int OFFSET_DIV      = 2,
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int DEBOUNCE_WIDTH  = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            i_pixel_y,
  input  logic                  i_enable,
  input  logic                  i_advance,
  input  logic                  i_hold,
  output logic [MODE_WIDTH-1:0] o_test_mode,
  output logic [2:0]            o_offset,
  output logic                  o_frame_strobe,
  output logic                  o_mode_changed
);

  localparam int DIV_WIDTH = (OFFSET_DIV > 1) ? $clog2(OFFSET_DIV) : 1;
  localparam logic [MODE_WIDTH-1:0]  MODE_LAST  = MODE_WIDTH'(NUM_MODES - 1);
  localparam logic [DWELL_WIDTH-1:0] DWELL_LAST = DWELL_WIDTH'(DWELL_FRAMES - 1);
  localparam logic [DIV_WIDTH-1:0]   DIV_LAST   = DIV_WIDTH'(OFFSET_DIV - 1);

  logic [7:0]            y_prev_q;
  logic                  strobe_q, changed_q;
  logic [1:0]            state_q, state_d;
  logic                  pend_q, pend_d;
  logic [MODE_WIDTH-1:0] mode_q, mode_d;
  logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [2:0]            offset_q, offset_d;
  logic                  adv_pulse, frame_start, active, step;
  logic                  unused_enable;

  assign unused_enable = i_enable;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DEBOUNCE_WIDTH (DEBOUNCE_WIDTH)
  ) u_adv_debounce (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (i_advance),
    .pulse_o(adv_pulse)
  );

  // Frame start is the first cycle back on line 0; all updates land on the
  // same edge that raises o_frame_strobe.
  assign frame_start = (i_pixel_y == 8'd0) && (y_prev_q != 8'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RUN;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  // A press arriving on the very step it would have caused is absorbed,
  // so coincident expiry and advance step the mode only once.
  always_comb begin
    pend_d  = step ? 1'b0 : (pend_q | adv_pulse);
    state_d = state_q;
    case (state_q)
      S_RUN:   if (i_hold) state_d = S_HOLD;
               else if (pend_d) state_d = S_PEND;
      S_PEND:  if (i_hold) state_d = S_HOLD;
               else if (!pend_d) state_d = S_RUN;
      S_HOLD:  if (!i_hold) state_d = pend_d ? S_PEND : S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    active   = (state_q != S_HOLD) && !i_hold;
    step     = active && frame_start && ((state_q == S_PEND) || (dwell_q == DWELL_LAST));
    mode_d   = mode_q;
    dwell_d  = dwell_q;
    div_d    = div_q;
    offset_d = offset_q;
    if (active && frame_start) begin
      if (step) begin
        mode_d  = (mode_q == MODE_LAST) ? '0 : mode_q + MODE_WIDTH'(1);
        dwell_d = '0;
      end else begin
        dwell_d = dwell_q + DWELL_WIDTH'(1);
      end
      if (div_q == DIV_LAST) begin
        div_d    = '0;
        offset_d = offset_q + 3'd1;
      end else begin
        div_d = div_q + DIV_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y_prev_q  <= '0;
      strobe_q  <= 1'b0;
      changed_q <= 1'b0;
      mode_q    <= '0;
      dwell_q   <= '0;
      div_q     <= '0;
      offset_q  <= '0;
    end else begin
      y_prev_q  <= i_pixel_y;
      strobe_q  <= frame_start;
      changed_q <= step;
      mode_q    <= mode_d;
      dwell_q   <= dwell_d;
      div_q     <= div_d;
      offset_q  <= offset_d;
    end
  end

  assign o_test_mode    = mode_q;
  assign o_offset       = offset_q;
  assign o_frame_strobe = strobe_q;
  assign o_mode_changed = changed_q;

endmodule

`default_nettype wire

// File: tb/tb_video_mode_sequencer.sv
// ============================================================================
// Module : tb_video_mode_sequencer
// Brief  : Scoreboard bench: per-strobe expected mode/offset/changed values.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_video_mode_sequencer;

  localparam int NM  = 6;
  localparam int DW  = 3;
  localparam int OD  = 2;
  localparam int DBC = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] i_pixel_y = 8'd0;
  logic       i_enable = 1'b0;
  logic       i_advance = 1'b0;
  logic       i_hold = 1'b0;
  logic [2:0] o_test_mode;
  logic [2:0] o_offset;
  logic       o_frame_strobe;
  logic       o_mode_changed;

  int checks = 0;
  int errors = 0;
  int bad_mode = 0;
  int stray_change = 0;

  // {mode, offset, changed}
  logic [6:0] exp_q[$];
  logic [6:0] obs_q[$];

  int m_mode, m_off, m_div, m_dwell;
  bit m_pend;

  video_mode_sequencer #(
    .NUM_MODES(NM), .MODE_WIDTH(3), .DWELL_FRAMES(DW), .DWELL_WIDTH(8),
    .OFFSET_DIV(OD), .DEBOUNCE_CYCLES(DBC), .DEBOUNCE_WIDTH(18)
  ) dut (
    .clk(clk), .rst(rst), .i_pixel_y(i_pixel_y), .i_enable(i_enable),
    .i_advance(i_advance), .i_hold(i_hold), .o_test_mode(o_test_mode),
    .o_offset(o_offset), .o_frame_strobe(o_frame_strobe), .o_mode_changed(o_mode_changed)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    if (o_test_mode >= 3'(NM)) bad_mode++;
    if (o_mode_changed && !o_frame_strobe) stray_change++;
    if (o_frame_strobe) obs_q.push_back({o_test_mode, o_offset, o_mode_changed});
  endtask

  task automatic model_reset();
    m_mode = 0; m_off = 0; m_div = 0; m_dwell = 0; m_pend = 0;
  endtask

  task automatic model_strobe(input logic hold);
    bit stp;
    stp = 0;
    if (!hold) begin
      stp = m_pend || (m_dwell == DW - 1);
      if (stp) begin
        m_mode  = (m_mode == NM - 1) ? 0 : m_mode + 1;
        m_dwell = 0;
        m_pend  = 0;
      end else begin
        m_dwell++;
      end
      if (m_div == OD - 1) begin
        m_div = 0;
        m_off = (m_off + 1) % 8;
      end else begin
        m_div++;
      end
    end
    exp_q.push_back({3'(m_mode), 3'(m_off), stp});
  endtask

  // One 10-line frame; the strobe for this frame start lands on cycle 0.
  task automatic drive_frame(input int adv_start, input int adv_len, input logic hold_mid);
    model_strobe(i_hold);
    for (int c = 0; c < 100; c++) begin
      i_pixel_y = 8'(c / 10);
      i_enable  = (c / 10) < 8;
      i_advance = (adv_start >= 0) && (c >= adv_start) && (c < adv_start + adv_len);
      if (c == 50) i_hold = hold_mid;
      tick();
    end
    i_advance = 1'b0;
    if (adv_start >= 0 && adv_len > DBC) m_pend = 1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    i_pixel_y = 8'd0;
    repeat (3) tick();
    checks++; if (o_test_mode !== 3'd0) begin errors++; $display("FAIL reset_mode got %0d want 0", o_test_mode); end
    checks++; if (o_offset !== 3'd0) begin errors++; $display("FAIL reset_offset got %0d want 0", o_offset); end
    checks++; if (o_frame_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe got %0b want 0", o_frame_strobe); end
    checks++; if (o_mode_changed !== 1'b0) begin errors++; $display("FAIL reset_changed got %0b want 0", o_mode_changed); end
    i_pixel_y = 8'd5;
    repeat (3) tick();
    rst = 1'b1;
    model_reset();
    for (int c = 53; c < 100; c++) begin
      i_pixel_y = 8'(c / 10);
      tick();
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL reset_no_early_strobe got %0d strobes want 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_free_run();
    logic [6:0] e, o;
    for (int f = 0; f < 20; f++) drive_frame(-1, 0, 1'b0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL free_run_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL free_run_strobe got mode=%0d off=%0d chg=%0b want mode=%0d off=%0d chg=%0b",
                 o[6:4], o[3:1], o[0], e[6:4], e[3:1], e[0]);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_advance_bounce();
    logic [6:0] e, o;
    while (m_dwell != 0) drive_frame(-1, 0, 1'b0);
    drive_frame(30, 3, 1'b0);
    drive_frame(-1, 0, 1'b0);
    drive_frame(30, 10, 1'b0);
    drive_frame(-1, 0, 1'b0);
    drive_frame(-1, 0, 1'b0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL advance_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL advance_strobe got mode=%0d off=%0d chg=%0b want mode=%0d off=%0d chg=%0b",
                 o[6:4], o[3:1], o[0], e[6:4], e[3:1], e[0]);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_coincide();
    logic [6:0] e, o;
    while (m_dwell != DW - 1) drive_frame(-1, 0, 1'b0);
    drive_frame(40, 10, 1'b0);
    for (int f = 0; f < 4; f++) drive_frame(-1, 0, 1'b0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL coincide_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL coincide_strobe got mode=%0d off=%0d chg=%0b want mode=%0d off=%0d chg=%0b",
                 o[6:4], o[3:1], o[0], e[6:4], e[3:1], e[0]);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_hold();
    logic [6:0] e, o;
    drive_frame(-1, 0, 1'b1);
    drive_frame(-1, 0, 1'b1);
    drive_frame(20, 10, 1'b1);
    drive_frame(-1, 0, 1'b1);
    drive_frame(-1, 0, 1'b1);
    drive_frame(-1, 0, 1'b0);
    for (int f = 0; f < 4; f++) drive_frame(-1, 0, 1'b0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL hold_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL hold_strobe got mode=%0d off=%0d chg=%0b want mode=%0d off=%0d chg=%0b",
                 o[6:4], o[3:1], o[0], e[6:4], e[3:1], e[0]);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_wrap();
    logic [6:0] e, o;
    while (m_mode != NM - 1) drive_frame(-1, 0, 1'b0);
    drive_frame(30, 10, 1'b0);
    drive_frame(-1, 0, 1'b0);
    checks++;
    if (o_test_mode !== 3'd0) begin errors++; $display("FAIL wrap_mode got %0d want 0", o_test_mode); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL wrap_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL wrap_strobe got mode=%0d off=%0d chg=%0b want mode=%0d off=%0d chg=%0b",
                 o[6:4], o[3:1], o[0], e[6:4], e[3:1], e[0]);
      end
    end
    exp_q.delete(); obs_q.delete();
    checks++; if (bad_mode != 0) begin errors++; $display("FAIL mode_range got %0d bad samples want 0", bad_mode); end
    checks++; if (stray_change != 0) begin errors++; $display("FAIL change_without_strobe got %0d want 0", stray_change); end
  endtask

  task automatic test_async_reset();
    for (int c = 0; c < 55; c++) begin
      i_pixel_y = 8'(c / 10);
      tick();
    end
    #2 rst = 1'b0;
    #1;
    checks++; if (o_test_mode !== 3'd0) begin errors++; $display("FAIL async_reset_mode got %0d want 0", o_test_mode); end
    checks++; if (o_offset !== 3'd0) begin errors++; $display("FAIL async_reset_offset got %0d want 0", o_offset); end
    checks++; if (o_frame_strobe !== 1'b0) begin errors++; $display("FAIL async_reset_strobe got %0b want 0", o_frame_strobe); end
    checks++; if (o_mode_changed !== 1'b0) begin errors++; $display("FAIL async_reset_changed got %0b want 0", o_mode_changed); end
    obs_q.delete();
    rst = 1'b1;
    repeat (2) tick();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_free_run();
    test_advance_bounce();
    test_coincide();
    test_hold();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
